// File: rtl/magic_device_pkg.sv
// Shared definitions for the magic device arbiter: FSM state encoding,
// bus widths and the data word returned on a device timeout.
package magic_device_pkg;

    localparam int SELECT_W = 12;
    localparam int DATA_W   = 64;

    // Response data delivered when the device never answers
    localparam logic [DATA_W-1:0] TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/magic_device_rr_pick.sv
// Round-robin selector: returns the first requester after last_grant
// (wrapping) that has its request bit set, plus a flag that any request exists.
module magic_device_rr_pick #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last_grant,
    output logic [W-1:0] winner,
    output logic         any
);

    // Two descending passes: the lowest index at or below last_grant is the
    // wrap-around fallback, and any requester above last_grant overrides it.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (W'(i) <= last_grant)) begin
                winner = W'(i);
                any    = 1'b1;
            end
        end
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i] && (W'(i) > last_grant)) begin
                winner = W'(i);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/magic_device_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single magic device read port, one
// transaction in flight at a time, round-robin fairness between requesters.
// Optional feature: define MAGIC_DEVICE_ARBITER_TIMEOUT_EN to enable the
// ISSUE watchdog that answers with TIMEOUT_DATA and resp_err=1 after
// TIMEOUT_CYCLES cycles without dev_read_valid.
module magic_device_arbiter
    import magic_device_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ*SELECT_W-1:0]  req_select,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [NUM_REQ-1:0]           resp_valid,
    input  logic [NUM_REQ-1:0]           resp_ready,
    output logic [DATA_W-1:0]            resp_data,
    output logic                         resp_err,
    output logic [SELECT_W-1:0]          dev_read_select,
    output logic                         dev_read_ready,
    input  logic                         dev_read_valid,
    input  logic [DATA_W-1:0]            dev_read_data
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("magic_device_arbiter: NUM_REQ out of range 2..8");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("magic_device_arbiter: TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t              state;
    logic [IDX_W-1:0]    last_grant;
    logic [IDX_W-1:0]    grant_idx;
    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [SELECT_W-1:0] pick_sel;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == idx) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    magic_device_rr_pick #(
        .N (NUM_REQ),
        .W (IDX_W)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .winner     (pick_idx),
        .any        (pick_any)
    );

    // Select field of the current round-robin winner
    always_comb begin
        pick_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (IDX_W'(i) == pick_idx) begin
                pick_sel = req_select[i*SELECT_W +: SELECT_W];
            end
        end
    end

    // Accept is combinational so the winner is told in the same IDLE cycle
    always_comb begin
        req_ready = '0;
        if (state == ST_IDLE && pick_any) begin
            req_ready = onehot(pick_idx);
        end
    end

`ifdef MAGIC_DEVICE_ARBITER_TIMEOUT_EN
    logic [15:0] timeout_cnt;

    // Transaction FSM with ISSUE watchdog; all outputs registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            last_grant      <= IDX_W'(NUM_REQ - 1);
            grant_idx       <= '0;
            dev_read_ready  <= 1'b0;
            dev_read_select <= '0;
            resp_valid      <= '0;
            resp_data       <= '0;
            resp_err        <= 1'b0;
            timeout_cnt     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx       <= pick_idx;
                        dev_read_select <= pick_sel;
                        dev_read_ready  <= 1'b1;
                        timeout_cnt     <= '0;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dev_read_valid) begin
                        dev_read_ready  <= 1'b0;
                        dev_read_select <= '0;
                        resp_data       <= dev_read_data;
                        resp_err        <= 1'b0;
                        resp_valid      <= onehot(grant_idx);
                        timeout_cnt     <= '0;
                        state           <= ST_RESP;
                    end else if (timeout_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        dev_read_ready  <= 1'b0;
                        dev_read_select <= '0;
                        resp_data       <= TIMEOUT_DATA;
                        resp_err        <= 1'b1;
                        resp_valid      <= onehot(grant_idx);
                        timeout_cnt     <= '0;
                        state           <= ST_RESP;
                    end else begin
                        timeout_cnt <= timeout_cnt + 16'd1;
                    end
                end
                ST_RESP: begin
                    if (resp_ready[grant_idx]) begin
                        resp_valid <= '0;
                        resp_data  <= '0;
                        resp_err   <= 1'b0;
                        last_grant <= grant_idx;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`else
    assign resp_err = 1'b0;

    // Transaction FSM; ISSUE waits for the device indefinitely
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            last_grant      <= IDX_W'(NUM_REQ - 1);
            grant_idx       <= '0;
            dev_read_ready  <= 1'b0;
            dev_read_select <= '0;
            resp_valid      <= '0;
            resp_data       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        grant_idx       <= pick_idx;
                        dev_read_select <= pick_sel;
                        dev_read_ready  <= 1'b1;
                        state           <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (dev_read_valid) begin
                        dev_read_ready  <= 1'b0;
                        dev_read_select <= '0;
                        resp_data       <= dev_read_data;
                        resp_valid      <= onehot(grant_idx);
                        state           <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready[grant_idx]) begin
                        resp_valid <= '0;
                        resp_data  <= '0;
                        last_grant <= grant_idx;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_magic_device_arbiter.sv
// Directed bench for magic_device_arbiter (4 requesters, TIMEOUT_CYCLES=8).
// Timeout expectations follow MAGIC_DEVICE_ARBITER_TIMEOUT_EN.
module tb_magic_device_arbiter;

    logic         clock;
    logic         reset_n;
    logic [3:0]   req_valid;
    logic [47:0]  req_select;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [3:0]   resp_ready;
    logic [63:0]  resp_data;
    logic         resp_err;
    logic [11:0]  dev_read_select;
    logic         dev_read_ready;
    logic         dev_read_valid;
    logic [63:0]  dev_read_data;

    int total = 0;
    int bad   = 0;

    magic_device_arbiter #(
        .NUM_REQ        (4),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .req_valid       (req_valid),
        .req_select      (req_select),
        .req_ready       (req_ready),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_err        (resp_err),
        .dev_read_select (dev_read_select),
        .dev_read_ready  (dev_read_ready),
        .dev_read_valid  (dev_read_valid),
        .dev_read_data   (dev_read_data)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [3:0]  oh;
        logic [63:0] dat;

        reset_n        = 1'b0;
        req_valid      = '0;
        req_select     = '0;
        resp_ready     = '0;
        dev_read_valid = 1'b0;
        dev_read_data  = '0;

        // Reset state
        #3;
        chk("rst_req_ready", req_ready, 4'b0000);
        chk("rst_resp_valid", resp_valid, 4'b0000);
        chk("rst_resp_data", resp_data, 64'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_dev_ready", dev_read_ready, 1'b0);
        chk("rst_dev_select", dev_read_select, 12'h000);
        @(negedge clock);
        reset_n = 1'b1;
        tick();

        // Single request from requester 2, device answers on 4th ISSUE cycle
        req_valid = 4'b0100;
        req_select[2*12 +: 12] = 12'h0A5;
        #1;
        chk("t1_accept", req_ready, 4'b0100);
        chk("t1_dev_idle", dev_read_ready, 1'b0);
        tick();
        req_valid = '0;
        #1;
        chk("t1_ready_off", req_ready, 4'b0000);
        chk("t1_dev_ready", dev_read_ready, 1'b1);
        chk("t1_dev_select", dev_read_select, 12'h0A5);
        tick(); #1;
        chk("t1_wait1", dev_read_ready, 1'b1);
        tick(); #1;
        chk("t1_wait2", dev_read_ready, 1'b1);
        tick();
        dev_read_valid = 1'b1;
        dev_read_data  = 64'h1234;
        #1;
        chk("t1_sel_stable", dev_read_select, 12'h0A5);
        tick();
        dev_read_valid = 1'b0;
        dev_read_data  = '0;
        #1;
        chk("t1_resp_valid", resp_valid, 4'b0100);
        chk("t1_resp_data", resp_data, 64'h1234);
        chk("t1_resp_err", resp_err, 1'b0);
        chk("t1_dev_drop", dev_read_ready, 1'b0);
        resp_ready = 4'b0100;
        tick();
        resp_ready = '0;
        #1;
        chk("t1_resp_clear", resp_valid, 4'b0000);
        chk("t1_data_clear", resp_data, 64'h0);

        // Spurious device valid while IDLE
        dev_read_valid = 1'b1;
        dev_read_data  = 64'hFFFF_0000_FFFF_0000;
        tick(); #1;
        chk("sp_resp_valid", resp_valid, 4'b0000);
        chk("sp_resp_data", resp_data, 64'h0);
        chk("sp_dev_ready", dev_read_ready, 1'b0);
        tick();
        dev_read_valid = 1'b0;
        #1;
        chk("sp_resp_valid2", resp_valid, 4'b0000);

        // Backpressure on requester 1 (last grant 2 -> 1 is next requesting)
        req_valid = 4'b0010;
        req_select[1*12 +: 12] = 12'h0B1;
        dev_read_valid = 1'b1;
        dev_read_data  = 64'hFEED_FACE_0000_0001;
        #1;
        chk("bp_accept", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1111;
        #1;
        chk("bp_issue_ready", req_ready, 4'b0000);
        chk("bp_dev_select", dev_read_select, 12'h0B1);
        tick(); #1;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_valid_%0d", k), resp_valid, 4'b0010);
            chk($sformatf("bp_data_%0d", k), resp_data, 64'hFEED_FACE_0000_0001);
            chk($sformatf("bp_noaccept_%0d", k), req_ready, 4'b0000);
            tick(); #1;
        end
        resp_ready = 4'b0010;
        chk("bp_hold_last", resp_valid, 4'b0010);
        tick();
        resp_ready = '0;
        #1;
        chk("bp_released", resp_valid, 4'b0000);
        chk("bp_next_rr", req_ready, 4'b0100);
        req_valid      = '0;
        dev_read_valid = 1'b0;
        dev_read_data  = '0;
        #1;

        // Silent device (last grant 1 -> requester 0)
        req_valid = 4'b0001;
        req_select[0*12 +: 12] = 12'h0C0;
        #1;
        chk("to_accept", req_ready, 4'b0001);
        tick();
        req_valid = '0;
`ifdef MAGIC_DEVICE_ARBITER_TIMEOUT_EN
        repeat (7) tick();
        #1;
        chk("to_issue8", dev_read_ready, 1'b1);
        chk("to_no_resp", resp_valid, 4'b0000);
        tick(); #1;
        chk("to_resp_valid", resp_valid, 4'b0001);
        chk("to_resp_data", resp_data, 64'hDEAD_DEAD_DEAD_DEAD);
        chk("to_resp_err", resp_err, 1'b1);
        chk("to_dev_drop", dev_read_ready, 1'b0);
        resp_ready = 4'b0001;
        tick();
        resp_ready = '0;
        #1;
        chk("to_err_clear", resp_err, 1'b0);
        chk("to_valid_clear", resp_valid, 4'b0000);
        req_valid = 4'b1000;
        tick();
        req_valid = '0;
`else
        repeat (20) tick();
        #1;
        chk("to_still_issue", dev_read_ready, 1'b1);
        chk("to_no_resp", resp_valid, 4'b0000);
        chk("to_err_tied", resp_err, 1'b0);
`endif

        // Reset while in ISSUE
        #1;
        chk("rs_in_issue", dev_read_ready, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rs_dev_drop", dev_read_ready, 1'b0);
        chk("rs_resp_valid", resp_valid, 4'b0000);
        tick();
        tick();
        chk("rs_no_resp", resp_valid, 4'b0000);
        @(negedge clock);
        reset_n = 1'b1;

        // All four requesting, zero device latency: order 0,1,2,3,0
        req_valid      = 4'b1111;
        resp_ready     = 4'b1111;
        dev_read_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_select[i*12 +: 12] = 12'h100 + 12'(i);
        end
        #1;
        for (int k = 0; k < 5; k++) begin
            oh  = 4'b0001 << (k % 4);
            dat = 64'h5A5A_0000_0000_0000 + 64'(k);
            dev_read_data = dat;
            #1;
            chk($sformatf("rr_accept_%0d", k), req_ready, oh);
            tick(); #1;
            chk($sformatf("rr_select_%0d", k), dev_read_select, 12'h100 + 12'(k % 4));
            chk($sformatf("rr_dev_ready_%0d", k), dev_read_ready, 1'b1);
            tick(); #1;
            chk($sformatf("rr_resp_valid_%0d", k), resp_valid, oh);
            chk($sformatf("rr_resp_data_%0d", k), resp_data, dat);
            tick();
        end
        req_valid      = '0;
        resp_ready     = '0;
        dev_read_valid = 1'b0;
        #1;
        chk("end_idle_resp", resp_valid, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/magic_device_arbiter.md
MAGIC_DEVICE_ARBITER -- requirements
Module: magic_device_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester ports (2..8).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, watchdog limit in cycles (1..65535).
REQ-003 SHALL have port clock, input, 1, single clock for all state.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester read request.
REQ-006 SHALL have port req_select, input, NUM_REQ*12, per-requester 12-bit select, requester i at bits [12i+11:12i].
REQ-007 SHALL have port req_ready, output, NUM_REQ, one-hot request accept.
REQ-008 SHALL have port resp_valid, output, NUM_REQ, one-hot response valid.
REQ-009 SHALL have port resp_ready, input, NUM_REQ, per-requester response accept.
REQ-010 SHALL have port resp_data, output, 64, shared response data.
REQ-011 SHALL have port resp_err, output, 1, response is timeout error.
REQ-012 SHALL have port dev_read_select, output, 12, select to magic device.
REQ-013 SHALL have port dev_read_ready, output, 1, read strobe to magic device.
REQ-014 SHALL have port dev_read_valid, input, 1, device data valid.
REQ-015 SHALL have port dev_read_data, input, 64, device data.

Function
REQ-016 SHALL implement FSM IDLE, ISSUE, RESP; one transaction in flight at a time.
REQ-017 IDLE: SHALL pick winner among req_valid by round-robin starting at (last_grant+1) mod NUM_REQ, assert req_ready[winner] combinationally, latch winner index and select, go to ISSUE next cycle.
REQ-018 ISSUE: SHALL drive dev_read_ready=1 and dev_read_select=latched select, both stable until dev_read_valid=1.
REQ-019 ISSUE: SHALL capture dev_read_data in the cycle dev_read_valid=1, deassert dev_read_ready the next cycle, go to RESP.
REQ-020 dev_read_valid while not in ISSUE SHALL be ignored.
REQ-021 RESP: SHALL hold resp_valid[winner]=1, resp_data, resp_err stable until resp_ready[winner]=1; then update last_grant=winner, go to IDLE.
REQ-022 Minimum latency SHALL be 1 cycle IDLE to ISSUE, device latency, 1 cycle to RESP; accept-to-next-accept minimum 3 cycles.
REQ-023 req_ready SHALL be all-zero outside IDLE; a requester dropping req_valid after acceptance SHALL not cancel the transaction.
REQ-024 resp_valid SHALL be all-zero outside RESP; resp_data SHALL be zero when resp_valid is all-zero.
REQ-025 Requester with req_valid held continuously SHALL be granted within NUM_REQ transactions.

Reset
REQ-026 reset_n low SHALL asynchronously force IDLE, last_grant=NUM_REQ-1 (first grant to requester 0), all outputs zero, timeout counter zero.
REQ-027 Reset mid-ISSUE SHALL drop dev_read_ready immediately; no response delivered for the aborted transaction.

Configuration
REQ-028 With MAGIC_DEVICE_ARBITER_TIMEOUT_EN defined: counter increments each ISSUE cycle; on reaching TIMEOUT_CYCLES without dev_read_valid, SHALL drop dev_read_ready, enter RESP with resp_data=64'hDEAD_DEAD_DEAD_DEAD and resp_err=1.
REQ-029 Without MAGIC_DEVICE_ARBITER_TIMEOUT_EN: no counter, ISSUE waits indefinitely, resp_err tied 0.

Structure
REQ-030 Shared package magic_device_pkg SHALL hold state enum, SELECT_W=12, DATA_W=64, timeout error constant.
REQ-031 Round-robin selector SHALL be sub-module magic_device_rr_pick (req vector, last_grant -> winner index, any).

Verification
REQ-032 Single request: req_valid[2]=1, select 12'h0A5, device returns 64'h1234 after 3 cycles -> req_ready[2] one cycle, dev_read_select=0A5, resp_valid[2] with 64'h1234, resp_err=0.
REQ-033 All four requesting continuously, device latency 0 -> grant order 0,1,2,3,0, each response to its own requester.
REQ-034 Backpressure: resp_ready[1]=0 for 5 cycles -> resp_valid[1] and resp_data stable 5 cycles, no new req_ready.
REQ-035 Timeout (macro defined, TIMEOUT_CYCLES=8), device silent -> after 8 ISSUE cycles resp_err=1, resp_data=DEAD_DEAD_DEAD_DEAD; macro undefined -> stays in ISSUE.
REQ-036 reset_n low during ISSUE -> dev_read_ready 0 same cycle, after release next grant goes to requester 0.
REQ-037 Spurious dev_read_valid in IDLE -> no resp_valid, state unchanged.
